// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller slice: the byte width of
// the UART data path and the controller FSM state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // IDLE waits for a byte, UNLOAD pulses uld_rx_data, CAPTURE samples rx_data.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNLOAD  = 2'd1,
    CAPTURE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Show-ahead byte FIFO of DEPTH entries (power of two) between the UART
// receive controller and the byte consumer.
//
// Ports
//   rxclk    : clock
//   reset    : asynchronous active-high reset (pointers, level and storage)
//   i_push   : write i_data this cycle (ignored when full without a pop)
//   i_pop    : retire the head entry this cycle (ignored when empty)
//   i_flush  : synchronous clear, overrides push and pop in the same cycle
//   i_data   : byte to write
//   o_level  : current occupancy, 0..DEPTH
//   o_head   : oldest entry (meaningful only when o_level != 0)
//   o_full   : o_level == DEPTH
// -----------------------------------------------------------------------------
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      rxclk,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [UART_DATA_W-1:0]    i_data,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic [UART_DATA_W-1:0]    o_head,
  output logic                      o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic w_push;
  logic w_pop;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_level != '0);
  assign w_push = i_push && (!o_full || w_pop);

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Drains bytes from a UART receiver into a show-ahead FIFO. A three-state FSM
// unloads one byte per sequence (IDLE -> UNLOAD -> CAPTURE), bytes arriving
// while the FIFO is full are dropped and counted.
//
// Ports
//   rxclk            : clock shared with the UART receiver
//   reset            : asynchronous active-high reset
//   en               : software receive enable
//   flush            : synchronous FIFO clear
//   uart_rx_enable   : en delayed one cycle, to UART rx_enable
//   uart_uld_rx_data : one-cycle unload pulse, to UART uld_rx_data
//   uart_rx_data     : UART received byte
//   uart_rx_empty    : UART holding register empty
//   m_valid/m_data   : FIFO head byte and its valid flag
//   m_ready          : consumer takes the head byte
//   fifo_level       : FIFO occupancy
//   drop_cnt         : saturating count of bytes lost to a full FIFO
//   idle             : FSM is in IDLE
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   rxclk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  output logic                   uart_rx_enable,
  output logic                   uart_uld_rx_data,
  input  logic [UART_DATA_W-1:0] uart_rx_data,
  input  logic                   uart_rx_empty,
  output logic                   m_valid,
  output logic [UART_DATA_W-1:0] m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   idle
);

  rx_state_e        r_state;
  logic             r_rx_enable;
  logic             r_uld;
  logic             r_idle;
  logic [CNT_W-1:0] r_drop_cnt;

  logic                   w_capture;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic [$clog2(DEPTH):0] w_level;

  assign w_capture = (r_state == CAPTURE);
  assign w_pop     = m_valid && m_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  // A byte lost to flush is not an overflow, so it is not counted.
  assign w_drop    = w_capture && w_full && !w_pop && !flush;

  assign uart_rx_enable   = r_rx_enable;
  assign uart_uld_rx_data = r_uld;
  assign idle             = r_idle;
  assign drop_cnt         = r_drop_cnt;
  assign fifo_level       = w_level;
  assign m_valid          = (w_level != '0);

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .rxclk   (rxclk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (uart_rx_data),
    .o_level (w_level),
    .o_head  (m_data),
    .o_full  (w_full)
  );

  // Receive enable towards the UART, one cycle behind software en.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_rx_enable <= 1'b0;
    end else begin
      r_rx_enable <= en;
    end
  end

  // Unload sequencer with registered uld pulse and idle flag.
  // A sequence starts only once the UART itself has been enabled (registered
  // enable), and an already started sequence always runs to completion.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_uld   <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && r_rx_enable && !uart_rx_empty) begin
            r_state <= UNLOAD;
            r_uld   <= 1'b1;
            r_idle  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_uld   <= 1'b0;
            r_idle  <= 1'b1;
          end
        end
        UNLOAD: begin
          r_state <= CAPTURE;
          r_uld   <= 1'b0;
          r_idle  <= 1'b0;
        end
        CAPTURE: begin
          r_state <= IDLE;
          r_uld   <= 1'b0;
          r_idle  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_uld   <= 1'b0;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of bytes discarded because the FIFO was full.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int DMAX  = (1 << CNT_W) - 1;

  logic       rxclk;
  logic       reset;
  logic       en;
  logic       flush;
  logic       uart_rx_enable;
  logic       uart_uld_rx_data;
  logic [7:0] uart_rx_data;
  logic       uart_rx_empty;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [3:0] fifo_level;
  logic [7:0] drop_cnt;
  logic       idle;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: FIFO contents, unload sequence position, enable, drops
  logic [7:0] mq[$];
  int         m_phase  = 0;   // 0 waiting, 1 unload cycle, 2 capture cycle
  logic       m_en_reg = 1'b0;
  int         m_drop   = 0;

  // UART environment: bytes still on the line and post-unload settle gap
  logic [7:0] uart_q[$];
  int         gap = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .rxclk            (rxclk),
    .reset            (reset),
    .en               (en),
    .flush            (flush),
    .uart_rx_enable   (uart_rx_enable),
    .uart_uld_rx_data (uart_uld_rx_data),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_empty    (uart_rx_empty),
    .m_valid          (m_valid),
    .m_data           (m_data),
    .m_ready          (m_ready),
    .fifo_level       (fifo_level),
    .drop_cnt         (drop_cnt),
    .idle             (idle)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  task automatic model_env_clear();
    mq.delete();
    m_phase  = 0;
    m_en_reg = 1'b0;
    m_drop   = 0;
    uart_q.delete();
    gap           = 0;
    uart_rx_empty = 1'b1;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // let the UART environment react to the unload pulse seen before the edge.
  task automatic tick();
    logic uld_pre;
    bit   cap;
    bit   pop;
    uld_pre = uart_uld_rx_data;
    if (reset) begin
      mq.delete();
      m_phase  = 0;
      m_en_reg = 1'b0;
      m_drop   = 0;
    end else begin
      cap = (m_phase == 2);
      pop = (mq.size() != 0) && m_ready;
      if (flush) begin
        mq.delete();
      end else if (cap && (mq.size() >= DEPTH) && !pop) begin
        if (m_drop < DMAX) m_drop++;
      end else begin
        if (pop) void'(mq.pop_front());
        if (cap) mq.push_back(uart_rx_data);
      end
      case (m_phase)
        0:       m_phase = (en && m_en_reg && !uart_rx_empty) ? 1 : 0;
        1:       m_phase = 2;
        default: m_phase = 0;
      endcase
      m_en_reg = en;
    end
    @(posedge rxclk);
    #1;
    if (uld_pre) begin
      uart_rx_empty = 1'b1;
      gap = 1;
    end else if (gap > 0) begin
      gap--;
    end else if (uart_rx_empty && uart_q.size() != 0) begin
      uart_rx_data  = uart_q.pop_front();
      uart_rx_empty = 1'b0;
    end
    @(negedge rxclk);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (uart_q.size() == 0 && uart_rx_empty && gap == 0 && m_phase == 0) break;
      tick();
    end
    n_checks++;
    if (k >= budget) $display("FAIL drain_timeout: waited %0d cycles, required fewer", k);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (uart_rx_enable !== 1'b0) $display("FAIL rst_rx_enable: got %b want 0", uart_rx_enable); else n_pass++;
    n_checks++; if (uart_uld_rx_data !== 1'b0) $display("FAIL rst_uld: got %b want 0", uart_uld_rx_data); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL rst_data: got %h want 00", m_data); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (uart_rx_enable !== 1'b0) $display("FAIL en_off: got %b want 0", uart_rx_enable); else n_pass++;
    en = 1'b1;
    tick();
    n_checks++; if (uart_rx_enable !== 1'b1) $display("FAIL en_reg: got %b want 1", uart_rx_enable); else n_pass++;
  endtask

  task automatic test_single_byte();
    uart_q.push_back(8'hA5);
    tick();
    n_checks++; if (uart_uld_rx_data !== 1'b0) $display("FAIL single_uld_early: got %b want 0", uart_uld_rx_data); else n_pass++;
    tick();
    n_checks++; if (uart_uld_rx_data !== 1'b1) $display("FAIL single_uld: got %b want 1", uart_uld_rx_data); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL single_idle: got %b want 0", idle); else n_pass++;
    tick();
    n_checks++; if (uart_uld_rx_data !== 1'b0) $display("FAIL single_uld_len: got %b want 0", uart_uld_rx_data); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL single_level_early: got %0d want 0", fifo_level); else n_pass++;
    tick();
    n_checks++; if (m_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'hA5) $display("FAIL single_data: got %h want a5", m_data); else n_pass++;
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL single_pop: got %0d want 0", fifo_level); else n_pass++;
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) uart_q.push_back(8'(i));
    wait_drain(200);
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL ovf_drop: got %0d want 1", drop_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (m_data !== 8'(i)) $display("FAIL ovf_order%0d: got %h want %h", i, m_data, 8'(i)); else n_pass++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    n_checks++; if (m_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_b[8];
    int k;
    for (int i = 0; i < 8; i++) uart_q.push_back(8'h10 + 8'(i));
    wait_drain(200);
    uart_q.push_back(8'h3C);
    for (k = 0; k < 50 && m_phase != 2; k++) tick();
    n_checks++; if (m_phase != 2) $display("FAIL fullpop_timeout: waited %0d cycles", k); else n_pass++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL fullpop_level: got %0d want 8", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL fullpop_drop: got %0d want 1", drop_cnt); else n_pass++;
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h11 + 8'(i);
    exp_b[7] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (m_data !== exp_b[i]) $display("FAIL fullpop_order%0d: got %h want %h", i, m_data, exp_b[i]); else n_pass++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 308; i++) uart_q.push_back(8'(i));
    wait_drain(3000);
    n_checks++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop: got %0d want 255", drop_cnt); else n_pass++;
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL sat_level: got %0d want 8", fifo_level); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL sat_flush: got %0d want 0", fifo_level); else n_pass++;
  endtask

  task automatic test_en_drop();
    int k;
    int uld_seen;
    uart_q.push_back(8'h5A);
    for (k = 0; k < 50 && m_phase != 1; k++) tick();
    n_checks++; if (uart_uld_rx_data !== 1'b1) $display("FAIL endrop_uld: got %b want 1", uart_uld_rx_data); else n_pass++;
    en = 1'b0;
    tick();
    tick();
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL endrop_level: got %0d want 1", fifo_level); else n_pass++;
    n_checks++; if (m_data !== 8'h5A) $display("FAIL endrop_data: got %h want 5a", m_data); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL endrop_idle: got %b want 1", idle); else n_pass++;
    uart_q.push_back(8'h77);
    uld_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (uart_uld_rx_data === 1'b1) uld_seen++;
    end
    n_checks++; if (uld_seen != 0) $display("FAIL endrop_no_uld: got %0d pulses want 0", uld_seen); else n_pass++;
    n_checks++; if (fifo_level !== 4'd1) $display("FAIL endrop_hold: got %0d want 1", fifo_level); else n_pass++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL endrop_pop: got %0d want 0", fifo_level); else n_pass++;
    en = 1'b1;
    for (int i = 1; i <= 4; i++) uart_q.push_back(8'(i));
    wait_drain(200);
    n_checks++; if (fifo_level !== 4'd5) $display("FAIL flush_pre: got %0d want 5", fifo_level); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL flush_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL flush_drop: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
  endtask

  task automatic test_reset_capture();
    int k;
    uart_q.push_back(8'h11);
    uart_q.push_back(8'h22);
    wait_drain(200);
    uart_q.push_back(8'h33);
    for (k = 0; k < 50 && m_phase != 2; k++) tick();
    n_checks++; if (idle !== 1'b0) $display("FAIL rcap_busy: got idle %b want 0", idle); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (uart_rx_enable !== 1'b0) $display("FAIL rcap_rx_enable: got %b want 0", uart_rx_enable); else n_pass++;
    n_checks++; if (uart_uld_rx_data !== 1'b0) $display("FAIL rcap_uld: got %b want 0", uart_uld_rx_data); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL rcap_valid: got %b want 0", m_valid); else n_pass++;
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL rcap_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rcap_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rcap_idle: got %b want 1", idle); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL rcap_data: got %h want 00", m_data); else n_pass++;
    model_env_clear();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (fifo_level !== 4'd0) $display("FAIL rcap_nopush: got %0d want 0", fifo_level); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      flush   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0 && uart_q.size() < 4) uart_q.push_back(8'($urandom_range(0, 255)));
      tick();
      n_checks++; if (fifo_level !== 4'(mq.size())) $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, mq.size()); else n_pass++;
      n_checks++; if (m_valid !== (mq.size() != 0)) $display("FAIL rnd_valid c%0d: got %b want %b", c, m_valid, mq.size() != 0); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (m_data !== mq[0]) $display("FAIL rnd_data c%0d: got %h want %h", c, m_data, mq[0]); else n_pass++;
      end
      n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_cnt, m_drop); else n_pass++;
      n_checks++; if (uart_uld_rx_data !== (m_phase == 1)) $display("FAIL rnd_uld c%0d: got %b want %b", c, uart_uld_rx_data, m_phase == 1); else n_pass++;
      n_checks++; if (idle !== (m_phase == 0)) $display("FAIL rnd_idle c%0d: got %b want %b", c, idle, m_phase == 0); else n_pass++;
      n_checks++; if (uart_rx_enable !== m_en_reg) $display("FAIL rnd_rx_enable c%0d: got %b want %b", c, uart_rx_enable, m_en_reg); else n_pass++;
    end
    flush   = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    en            = 1'b0;
    flush         = 1'b0;
    m_ready       = 1'b0;
    uart_rx_empty = 1'b1;
    uart_rx_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_en_drop();
    test_reset_capture();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
